// File: rtl/fifo_push_arb.sv
// Round-robin, packet-locked arbiter that shares one fifo write port among NREQ requesters.
// Optional macro FIFO_ARB_PRIO_EN gives requester 0 strict priority over the rotating others.
module fifo_push_arb #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int AW   = 4,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    input  logic [AW:0]       fifo_fill_level,
    output logic              fifo_push,
    output logic [DW-1:0]     fifo_din,
    output logic [IW-1:0]     grant_id,
    output logic              busy
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] winner;
    logic [IW-1:0] rr_next;
    logic [IW:0]   scan_idx;
    logic          found;
    logic          any_valid;
    logic [AW+1:0] committed;
    logic          space_ok;
    logic          accept;
    logic          accept_last;

    // Handshake: a beat moves when req_valid[i] & req_ready[i] at a rising edge.
    // req_ready never depends on req_valid; only the granted requester may see ready=1.

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + (IW+1)'(k);
            if (scan_idx >= (IW+1)'(NREQ)) begin
                scan_idx = scan_idx - (IW+1)'(NREQ);
            end
            if (!found && req_valid[scan_idx[IW-1:0]]) begin
                winner = scan_idx[IW-1:0];
                found  = 1'b1;
            end
        end
`ifdef FIFO_ARB_PRIO_EN
        if (req_valid[0]) begin
            winner = '0;
        end
`endif
    end

    assign any_valid = |req_valid;

    // The push still in flight is not yet counted in fill_level, so add it here.
    assign committed = {1'b0, fifo_fill_level} + {{(AW+1){1'b0}}, fifo_push};
    assign space_ok  = committed < (AW+2)'(DEPTH);

    assign accept      = (state == LOCK) && req_valid[grant_id] && space_ok;
    assign accept_last = accept && req_last[grant_id];
    assign rr_next     = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    assign busy        = (state == LOCK);

    always_comb begin
        req_ready = '0;
        if (state == LOCK) begin
            req_ready[grant_id] = space_ok;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            fifo_push <= 1'b0;
            fifo_din  <= '0;
        end else begin
            fifo_push <= accept;
            if (accept) begin
                fifo_din <= req_data[grant_id*DW +: DW];
            end
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant_id <= winner;
                        state    <= LOCK;
                    end
                end
                LOCK: begin
                    if (accept_last) begin
`ifdef FIFO_ARB_PRIO_EN
                        if (grant_id != '0) begin
                            rr_ptr <= rr_next;
                        end
`else
                        rr_ptr <= rr_next;
`endif
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_push_arb.sv
// Self-checking bench for fifo_push_arb: directed scenarios plus randomized traffic
// against a packet-level arbitration model and a modelled fifo occupancy.
`timescale 1ns/1ps
module tb_fifo_push_arb;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int IW    = 2;
    localparam int DEPTH = 16;
`ifdef FIFO_ARB_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                arst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_last;
    logic [NREQ-1:0]     req_ready;
    logic [AW:0]         fifo_fill_level;
    logic                fifo_push;
    logic [DW-1:0]       fifo_din;
    logic [IW-1:0]       grant_id;
    logic                busy;

    fifo_push_arb #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk             (clk),
        .arst_n          (arst_n),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_last        (req_last),
        .req_ready       (req_ready),
        .fifo_fill_level (fifo_fill_level),
        .fifo_push       (fifo_push),
        .fifo_din        (fifo_din),
        .grant_id        (grant_id),
        .busy            (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-requester beat queues: bit DW is the last flag.
    logic [DW:0]   beat_q [NREQ][$];
    logic [DW:0]   model_q[NREQ][$];
    logic [DW-1:0] exp_q[$];
    int            exp_owner[$];
    bit            started[NREQ];
    bit            gap_en, pop_en, overflow_seen, onehot_bad;
    int            occ;
    bit            pending_push;

    int              acc_idx;
    logic [NREQ-1:0] ready_s;
    logic            busy_s;
    logic [IW-1:0]   grant_s;
    logic            push_s;
    logic [DW-1:0]   din_s;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        arst_n = 1'b0;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            beat_q[i].delete();
            model_q[i].delete();
            started[i] = 1'b0;
        end
        exp_q.delete();
        exp_owner.delete();
        occ = 0;
        pending_push = 1'b0;
        overflow_seen = 1'b0;
        onehot_bad = 1'b0;
        gap_en = 1'b0;
        pop_en = 1'b0;
        fifo_fill_level = '0;
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_pkt(input int r, input int len);
        logic [DW:0] b;
        for (int k = 0; k < len; k++) begin
            b[DW-1:0] = DW'($urandom_range(0, 255));
            b[DW]     = (k == len - 1);
            beat_q[r].push_back(b);
            model_q[r].push_back(b);
        end
    endtask

    // One clock cycle: drive at negedge, record handshake before the edge,
    // update the fifo occupancy model and sample push/din after the edge.
    task automatic step();
        logic [DW:0] b;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (beat_q[i].size() > 0) begin
                req_valid[i] = (started[i] && gap_en) ? ($urandom_range(0, 3) != 0) : 1'b1;
                req_data[i*DW +: DW] = beat_q[i][0][DW-1:0];
                req_last[i] = beat_q[i][0][DW];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i*DW +: DW] = '0;
                req_last[i] = 1'b0;
            end
        end
        fifo_fill_level = (AW+1)'(occ);
        #1;
        ready_s = req_ready;
        busy_s  = busy;
        grant_s = grant_id;
        if ($countones(ready_s) > 1) onehot_bad = 1'b1;
        acc_idx = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                acc_idx = i;
                b = beat_q[i].pop_front();
                started[i] = !b[DW];
            end
        end
        @(posedge clk);
        #1;
        occ = occ + int'(pending_push);
        if (occ > DEPTH) overflow_seen = 1'b1;
        if (pop_en && occ > 0 && $urandom_range(0, 1) == 1) occ = occ - 1;
        pending_push = fifo_push;
        push_s = fifo_push;
        din_s  = fifo_din;
    endtask

    // Reference model: packet-level arbitration order after reset (pointer starts at 0).
    task automatic run_model();
        int p;
        int w;
        bit done;
        logic [DW:0] b;
        p = 0;
        done = 1'b0;
        while (!done) begin
            w = -1;
            if (PRIO && model_q[0].size() > 0) begin
                w = 0;
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    if (w < 0 && model_q[(p + k) % NREQ].size() > 0) w = (p + k) % NREQ;
                end
            end
            if (w < 0) begin
                done = 1'b1;
            end else begin
                do begin
                    b = model_q[w].pop_front();
                    exp_q.push_back(b[DW-1:0]);
                    exp_owner.push_back(w);
                end while (!b[DW]);
                if (!(PRIO && w == 0)) p = (w + 1) % NREQ;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(posedge clk);
        #2 arst_n = 1'b0;
        #1;
        n_checks++; if (fifo_push !== 1'b0) begin n_fail++; $display("FAIL reset_push: got %b expected 0", fifo_push); end
        n_checks++; if (fifo_din !== 8'h00) begin n_fail++; $display("FAIL reset_din: got %h expected 00", fifo_din); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
        do_reset();
    endtask

    task automatic test_single_beat();
        logic [3:0] exp_ready;
        do_reset();
        beat_q[2].push_back({1'b1, 8'hA5});
        step();
        n_checks++; if (ready_s !== 4'b0000 || acc_idx != -1) begin n_fail++; $display("FAIL single_arb_cycle: ready %b acc %0d expected 0000 -1", ready_s, acc_idx); end
        step();
        n_checks++; if (ready_s !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b expected 0100", ready_s); end
        n_checks++; if (grant_s !== 2'd2 || busy_s !== 1'b1) begin n_fail++; $display("FAIL single_grant: got %0d/%b expected 2/1", grant_s, busy_s); end
        n_checks++; if (push_s !== 1'b1 || din_s !== 8'hA5) begin n_fail++; $display("FAIL single_push: got %b/%h expected 1/a5", push_s, din_s); end
        load_pkt(0, 1);
        load_pkt(3, 1);
        step();
        n_checks++; if (busy_s !== 1'b0 || push_s !== 1'b0) begin n_fail++; $display("FAIL single_back_idle: busy %b push %b expected 0 0", busy_s, push_s); end
        step();
        exp_ready = PRIO ? 4'b0001 : 4'b1000;
        n_checks++; if (ready_s !== exp_ready) begin n_fail++; $display("FAIL single_rr_ptr: got %b expected %b", ready_s, exp_ready); end
    endtask

    task automatic test_round_robin();
        int acc_seq[$];
        int exp_seq[$];
        do_reset();
        load_pkt(0, 2); load_pkt(0, 2);
        load_pkt(1, 2); load_pkt(2, 2); load_pkt(3, 2);
        run_model();
        if (PRIO) exp_seq = '{0, 0, 0, 0, 1, 1, 2, 2, 3, 3};
        else      exp_seq = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        for (int c = 0; c < 40; c++) begin
            step();
            if (acc_idx >= 0) acc_seq.push_back(acc_idx);
            if (push_s === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL rr_data: unexpected push %h", din_s); end
                else if (din_s !== exp_q[0]) begin n_fail++; $display("FAIL rr_data: got %h expected %h", din_s, exp_q[0]); void'(exp_q.pop_front()); end
                else void'(exp_q.pop_front());
            end
        end
        n_checks++; if (acc_seq.size() != exp_seq.size()) begin n_fail++; $display("FAIL rr_count: got %0d expected %0d", acc_seq.size(), exp_seq.size()); end
        for (int k = 0; k < exp_seq.size() && k < acc_seq.size(); k++) begin
            n_checks++;
            if (acc_seq[k] != exp_seq[k]) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, acc_seq[k], exp_seq[k]); end
        end
    endtask

    task automatic test_fill_limit();
        int pushes;
        int late_ready;
        do_reset();
        load_pkt(1, 20);
        run_model();
        pushes = 0;
        late_ready = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (c >= 30 && ready_s !== 4'b0000) late_ready++;
            if (push_s === 1'b1) begin
                pushes++;
                n_checks++;
                if (exp_q.size() == 0 || din_s !== exp_q[0]) begin n_fail++; $display("FAIL fill_data: got %h", din_s); end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
        end
        n_checks++; if (pushes != DEPTH) begin n_fail++; $display("FAIL fill_pushes: got %0d expected %0d", pushes, DEPTH); end
        n_checks++; if (late_ready != 0) begin n_fail++; $display("FAIL fill_ready_held: got %0d ready cycles expected 0", late_ready); end
        n_checks++; if (overflow_seen) begin n_fail++; $display("FAIL fill_overflow: got 1 expected 0"); end
    endtask

    task automatic test_space_in_flight();
        do_reset();
        occ = 15;
        load_pkt(0, 3);
        step();
        n_checks++; if (ready_s !== 4'b0000) begin n_fail++; $display("FAIL inflight_idle: got %b expected 0000", ready_s); end
        step();
        n_checks++; if (ready_s !== 4'b0001) begin n_fail++; $display("FAIL inflight_fill15: got %b expected 0001", ready_s); end
        step();
        n_checks++; if (ready_s !== 4'b0000) begin n_fail++; $display("FAIL inflight_fill15_push: got %b expected 0000", ready_s); end
        step();
        n_checks++; if (ready_s !== 4'b0000) begin n_fail++; $display("FAIL inflight_full: got %b expected 0000", ready_s); end
        occ = 14;
        step();
        n_checks++; if (ready_s !== 4'b0001) begin n_fail++; $display("FAIL inflight_drop14: got %b expected 0001", ready_s); end
    endtask

    task automatic test_reset_mid_packet();
        int got;
        do_reset();
        load_pkt(2, 1);
        repeat (3) step();
        load_pkt(1, 5);
        got = 0;
        for (int c = 0; c < 10 && got < 2; c++) begin
            step();
            if (acc_idx == 1) got++;
        end
        n_checks++; if (got != 2 || busy !== 1'b1) begin n_fail++; $display("FAIL midpkt_setup: beats %0d busy %b expected 2 1", got, busy); end
        #2 arst_n = 1'b0;
        #1;
        n_checks++; if (fifo_push !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL midpkt_reset: push %b busy %b ready %b expected 0 0 0000", fifo_push, busy, req_ready);
        end
        do_reset();
        load_pkt(0, 1);
        load_pkt(3, 1);
        step();
        step();
        n_checks++; if (ready_s !== 4'b0001 || acc_idx != 0) begin n_fail++; $display("FAIL midpkt_restart: ready %b acc %0d expected 0001 0", ready_s, acc_idx); end
    endtask

    task automatic test_priority();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            load_pkt(0, 1);
            load_pkt(3, 1);
        end
        run_model();
        for (int c = 0; c < 40; c++) begin
            step();
            if (acc_idx >= 0) begin
                n_checks++;
                if (exp_owner.size() == 0) begin n_fail++; $display("FAIL prio_owner: unexpected beat from %0d", acc_idx); end
                else begin
                    if (acc_idx != exp_owner[0]) begin n_fail++; $display("FAIL prio_owner: got %0d expected %0d", acc_idx, exp_owner[0]); end
                    void'(exp_owner.pop_front());
                end
            end
        end
        n_checks++; if (exp_owner.size() != 0) begin n_fail++; $display("FAIL prio_drain: got %0d beats left expected 0", exp_owner.size()); end
    endtask

    task automatic test_random();
        int c;
        do_reset();
        gap_en = 1'b1;
        pop_en = 1'b1;
        for (int r = 0; r < NREQ; r++) begin
            for (int p = $urandom_range(1, 4); p > 0; p--) load_pkt(r, $urandom_range(1, 6));
        end
        run_model();
        c = 0;
        while ((exp_q.size() > 0 || exp_owner.size() > 0) && c < 4000) begin
            step();
            c++;
            if (acc_idx >= 0) begin
                n_checks++;
                if (exp_owner.size() == 0) begin n_fail++; $display("FAIL rand_owner: unexpected beat from %0d", acc_idx); end
                else begin
                    if (acc_idx != exp_owner[0]) begin n_fail++; $display("FAIL rand_owner: got %0d expected %0d", acc_idx, exp_owner[0]); end
                    void'(exp_owner.pop_front());
                end
            end
            if (push_s === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL rand_data: unexpected push %h", din_s); end
                else begin
                    if (din_s !== exp_q[0]) begin n_fail++; $display("FAIL rand_data: got %h expected %h", din_s, exp_q[0]); end
                    void'(exp_q.pop_front());
                end
            end
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_timeout: got %0d pushes missing expected 0", exp_q.size()); end
        n_checks++; if (overflow_seen) begin n_fail++; $display("FAIL rand_overflow: got 1 expected 0"); end
        n_checks++; if (onehot_bad) begin n_fail++; $display("FAIL rand_onehot: got multiple ready bits expected at most one"); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        arst_n = 1'b0;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        fifo_fill_level = '0;
        test_reset();
        test_single_beat();
        test_round_robin();
        test_fill_limit();
        test_space_in_flight();
        test_reset_mid_packet();
        test_priority();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
